// File: rtl/handshake_constant_seq_pkg.sv
// handshake_constant_seq_pkg: shared types and sizing helpers for counted handshake blocks
package handshake_constant_seq_pkg;

    typedef enum logic {IDLE, EMIT} state_t;

    // Counter width for values 0..n-1, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/handshake_constant_seq_if.sv
// handshake_constant_seq_if: ctrl token input and sequence output handshakes
interface handshake_constant_seq_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  ctrl_valid;
    logic                  ctrl_ready;
    logic [DATA_WIDTH-1:0] outs;
    logic                  outs_valid;
    logic                  outs_ready;
    logic                  outs_last;

    modport master (
        output ctrl_valid,
        input  ctrl_ready,
        input  outs,
        input  outs_valid,
        input  outs_last,
        output outs_ready
    );

    modport slave (
        input  ctrl_valid,
        output ctrl_ready,
        output outs,
        output outs_valid,
        output outs_last,
        input  outs_ready
    );
endinterface

// File: rtl/handshake_constant_seq.sv
// handshake_constant_seq: each ctrl token yields a registered burst VALUE, VALUE+STEP, ... of REPEAT tokens
module handshake_constant_seq
    import handshake_constant_seq_pkg::*;
#(
    parameter int     DATA_WIDTH = 32,
    parameter longint VALUE      = 0,
    parameter longint STEP       = 0,
    parameter int     REPEAT     = 1
) (
    input logic                     clk,
    input logic                     rst,
    handshake_constant_seq_if.slave bus
);
    localparam int CW = cnt_width(REPEAT);
    localparam logic [DATA_WIDTH-1:0] FIRST  = DATA_WIDTH'(VALUE);
    localparam logic [DATA_WIDTH-1:0] INC    = DATA_WIDTH'(STEP);
    localparam logic [CW-1:0]         PENULT = CW'(REPEAT - 2);

    if (REPEAT < 1) begin : g_bad_repeat
        $error("handshake_constant_seq: REPEAT must be >= 1");
    end

    state_t                state;
    logic [DATA_WIDTH-1:0] outs;
    logic                  last;
    logic [CW-1:0]         cnt;
    logic                  ready;
    logic                  ctrl_fire;
    logic                  out_fire;

    // A new token may enter while the final token of the current burst leaves
    assign ready     = (state == IDLE) || (last && bus.outs_ready);
    assign ctrl_fire = bus.ctrl_valid && ready;
    assign out_fire  = (state == EMIT) && bus.outs_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            outs  <= '0;
            last  <= 1'b0;
            cnt   <= '0;
        end else if (ctrl_fire) begin
            state <= EMIT;
            outs  <= FIRST;
            last  <= (REPEAT == 1);
            cnt   <= '0;
        end else if (out_fire) begin
            if (last) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                outs <= outs + INC;
                last <= (cnt == PENULT);
                cnt  <= cnt + CW'(1);
            end
        end
    end

    assign bus.ctrl_ready = ready;
    assign bus.outs       = outs;
    assign bus.outs_valid = (state == EMIT);
    assign bus.outs_last  = last;
endmodule

// File: tb/tb_handshake_constant_seq.sv
// tb_handshake_constant_seq: directed vector table over four parameter sets plus async-reset sequence
module tb_handshake_constant_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cv  = 1'b0;
    logic rdy = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    handshake_constant_seq_if #(.DATA_WIDTH(5)) ia ();
    handshake_constant_seq_if #(.DATA_WIDTH(8)) ib ();
    handshake_constant_seq_if #(.DATA_WIDTH(8)) ic ();
    handshake_constant_seq_if #(.DATA_WIDTH(8)) id ();

    assign ia.ctrl_valid = cv;
    assign ib.ctrl_valid = cv;
    assign ic.ctrl_valid = cv;
    assign id.ctrl_valid = cv;
    assign ia.outs_ready = rdy;
    assign ib.outs_ready = rdy;
    assign ic.outs_ready = rdy;
    assign id.outs_ready = rdy;

    handshake_constant_seq #(.DATA_WIDTH(5), .VALUE(15),  .STEP(0), .REPEAT(1)) u_a (.clk(clk), .rst(rst), .bus(ia));
    handshake_constant_seq #(.DATA_WIDTH(8), .VALUE(10),  .STEP(3), .REPEAT(4)) u_b (.clk(clk), .rst(rst), .bus(ib));
    handshake_constant_seq #(.DATA_WIDTH(8), .VALUE(250), .STEP(4), .REPEAT(3)) u_c (.clk(clk), .rst(rst), .bus(ic));
    handshake_constant_seq #(.DATA_WIDTH(8), .VALUE(7),   .STEP(1), .REPEAT(5)) u_d (.clk(clk), .rst(rst), .bus(id));

    logic [7:0] o  [4];
    logic       ov [4];
    logic       ol [4];
    logic       cr [4];

    assign o[0]  = {3'b000, ia.outs};
    assign o[1]  = ib.outs;
    assign o[2]  = ic.outs;
    assign o[3]  = id.outs;
    assign ov[0] = ia.outs_valid;
    assign ov[1] = ib.outs_valid;
    assign ov[2] = ic.outs_valid;
    assign ov[3] = id.outs_valid;
    assign ol[0] = ia.outs_last;
    assign ol[1] = ib.outs_last;
    assign ol[2] = ic.outs_last;
    assign ol[3] = id.outs_last;
    assign cr[0] = ia.ctrl_ready;
    assign cr[1] = ib.ctrl_ready;
    assign cr[2] = ic.ctrl_ready;
    assign cr[3] = id.ctrl_ready;

    typedef struct {
        logic       r;
        logic       cv;
        logic       rdy;
        int         sel;
        logic       cr;
        logic       ov;
        logic [7:0] o;
        logic       ol;
        logic       co;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic c, input logic d, input int s,
                       input logic ecr, input logic eov, input logic [7:0] eo, input logic eol, input logic eco);
        vec_t v;
        v.r = r; v.cv = c; v.rdy = d; v.sel = s;
        v.cr = ecr; v.ov = eov; v.o = eo; v.ol = eol; v.co = eco;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s @%0d: got %0d expected %0d", name, idx, got, exp);
        end
    endtask

    // Outputs checked only where defined: data/last while valid, or on rows flagged as reset state
    task automatic check(input int idx, input int s, input logic ecr, input logic eov,
                         input logic [7:0] eo, input logic eol, input logic eco);
        chk("ctrl_ready", idx, {7'd0, cr[s]}, {7'd0, ecr});
        chk("outs_valid", idx, {7'd0, ov[s]}, {7'd0, eov});
        if (eov || eco) begin
            chk("outs", idx, o[s], eo);
            chk("outs_last", idx, {7'd0, ol[s]}, {7'd0, eol});
        end
    endtask

    initial begin
        // A: REPEAT=1 constant stream, reset held with ctrl_valid high
        for (int i = 0; i < 3; i++) add(1, 1, 1, 0, 1, 0, 0, 0, 1);
        add(0, 1, 1, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) add(0, (i < 7), 1, 0, 1, 1, 15, 1, 0);
        add(0, 0, 1, 0, 1, 0, 0, 0, 0);
        // B: 10,13,16,19 with a second token held off until the last one
        add(1, 0, 1, 1, 1, 0, 0, 0, 1);
        add(0, 1, 1, 1, 1, 0, 0, 0, 0);
        add(0, 0, 1, 1, 0, 1, 10, 0, 0);
        add(0, 1, 1, 1, 0, 1, 13, 0, 0);
        add(0, 1, 1, 1, 0, 1, 16, 0, 0);
        add(0, 1, 1, 1, 1, 1, 19, 1, 0);
        add(0, 0, 1, 1, 0, 1, 10, 0, 0);
        add(0, 0, 1, 1, 0, 1, 13, 0, 0);
        add(0, 0, 1, 1, 0, 1, 16, 0, 0);
        add(0, 0, 1, 1, 1, 1, 19, 1, 0);
        add(0, 0, 1, 1, 1, 0, 0, 0, 0);
        // C: wrap 250,254,2 under ready pattern 1,0,0,1,0,0,1
        add(1, 0, 1, 2, 1, 0, 0, 0, 1);
        add(0, 1, 1, 2, 1, 0, 0, 0, 0);
        add(0, 0, 1, 2, 0, 1, 250, 0, 0);
        add(0, 1, 0, 2, 0, 1, 254, 0, 0);
        add(0, 1, 0, 2, 0, 1, 254, 0, 0);
        add(0, 0, 1, 2, 0, 1, 254, 0, 0);
        add(0, 0, 0, 2, 0, 1, 2, 1, 0);
        add(0, 0, 0, 2, 0, 1, 2, 1, 0);
        add(0, 0, 1, 2, 1, 1, 2, 1, 0);
        add(0, 0, 0, 2, 1, 0, 0, 0, 0);
        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].r;
            cv  = vecs[i].cv;
            rdy = vecs[i].rdy;
            #1;
            check(i, vecs[i].sel, vecs[i].cr, vecs[i].ov, vecs[i].o, vecs[i].ol, vecs[i].co);
        end
        // D: asynchronous reset in the middle of a REPEAT=5 burst
        @(negedge clk); rst = 1; cv = 0; rdy = 1;
        @(negedge clk); rst = 0; cv = 1;
        @(negedge clk); cv = 0; #1;
        check(100, 3, 0, 1, 7, 0, 0);
        @(negedge clk); #1;
        check(101, 3, 0, 1, 8, 0, 0);
        @(posedge clk); #3;
        rst = 1; #1;
        check(102, 3, 1, 0, 0, 0, 1);
        @(negedge clk); rst = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check(103 + i, 3, 1, 0, 0, 0, 0);
        end
        @(negedge clk); cv = 1;
        @(negedge clk); cv = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check(110 + i, 3, (i == 4), 1, 8'(7 + i), (i == 4), 0);
            @(negedge clk);
        end
        #1;
        check(120, 3, 1, 0, 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
